// File: rtl/inst_mem_responder_pkg.sv
// Shared constants and response-entry layout for the instruction-memory responder.
// The response FIFO stores one resp_entry_t per queued fetch.
package inst_mem_responder_pkg;

    localparam int          DEFAULT_DEPTH    = 1024;
    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

    localparam int INST_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int ERR_W   = 1;
    localparam int ENTRY_W = INST_W + ADDR_W + ERR_W;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] addr;
        logic [ERR_W-1:0]  err;
    } resp_entry_t;

    // Even parity: stored bit makes the XOR of word plus parity equal zero.
    function automatic logic even_parity(input logic [INST_W-1:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/resp_fifo2.sv
// Generic 2-entry valid/ready FIFO with synchronous clear (pointers only)
// and reset (pointers plus storage, so the head reads zero after reset).
module resp_fifo2 #(
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] head
);

    logic [1:0][WIDTH-1:0] store;
    logic                  rptr;
    logic                  wptr;
    logic [1:0]            count;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && (count != 2'd2);
    assign do_pop  = pop  && (count != 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            store <= '0;
            rptr  <= 1'b0;
            wptr  <= 1'b0;
            count <= 2'd0;
        end else if (clear) begin
            rptr  <= 1'b0;
            wptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (do_push) begin
                store[wptr] <= push_data;
                wptr        <= ~wptr;
            end
            if (do_pop) begin
                rptr <= ~rptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign full  = (count == 2'd2);
    assign valid = (count != 2'd0);
    assign head  = store[rptr];

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-fetch responder: owns instruction memory, answers word fetches via a 2-deep FIFO.
// Optional parity storage/checking is enabled with `define INST_MEM_PARITY_EN.
module inst_mem_responder
    import inst_mem_responder_pkg::*;
#(
    parameter int          DEPTH    = DEFAULT_DEPTH,
    parameter int          AW       = $clog2(DEPTH),
    parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_addr,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_inst,
    output logic [31:0]   resp_addr,
    output logic          resp_err,
    input  logic          flush,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
`ifdef INST_MEM_PARITY_EN
    input  logic          inject_par_err,
`endif
    input  logic [31:0]   ld_data
);

    logic [31:0] mem [DEPTH];
`ifdef INST_MEM_PARITY_EN
    logic        mem_par [DEPTH];
`endif

    logic [AW-1:0] index;
    logic [31:0]   rd_word;
    logic          misaligned;
    logic          out_of_range;
    logic          par_bad;
    logic          err;
    logic          accept;
    logic          pop;
    logic          full;
    resp_entry_t   push_e;
    resp_entry_t   head_e;

    assign index        = req_addr[AW+1:2];
    assign rd_word      = mem[index];
    assign misaligned   = |req_addr[1:0];
    assign out_of_range = |req_addr[31:AW+2];

`ifdef INST_MEM_PARITY_EN
    assign par_bad = (mem_par[index] != even_parity(rd_word));
`else
    assign par_bad = 1'b0;
`endif

    assign err = misaligned || out_of_range || par_bad;

    always_comb begin
        push_e      = '0;
        push_e.inst = err ? NOP_INST : rd_word;
        push_e.addr = req_addr;
        push_e.err  = err;
    end

    // No path from resp_ready: a full FIFO stays closed even if it pops this cycle.
    assign req_ready = !full && !flush && !reset;
    assign accept    = req_valid && req_ready;
    assign pop       = resp_valid && resp_ready;

    // Memory is never reset; the read above sees the pre-write word on a same-edge load.
    always_ff @(posedge clk) begin
        if (!reset && ld_we) begin
            mem[ld_addr] <= ld_data;
`ifdef INST_MEM_PARITY_EN
            mem_par[ld_addr] <= even_parity(ld_data) ^ inject_par_err;
`endif
        end
    end

    resp_fifo2 #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (accept),
        .push_data (push_e),
        .pop       (pop),
        .full      (full),
        .valid     (resp_valid),
        .head      (head_e)
    );

    assign resp_inst = head_e.inst;
    assign resp_addr = head_e.addr;
    assign resp_err  = head_e.err;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder: queue-based reference model checked every cycle,
// plus literal expectations taken from the fetch test scenarios.
module tb_inst_mem_responder;

    localparam int          DEPTH = 1024;
    localparam int          AW    = 10;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_inst;
    logic [31:0]   resp_addr;
    logic          resp_err;
    logic          flush;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic          inj;

    always #5 clk = ~clk;

    inst_mem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_inst  (resp_inst),
        .resp_addr  (resp_addr),
        .resp_err   (resp_err),
        .flush      (flush),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
`ifdef INST_MEM_PARITY_EN
        .inject_par_err (inj),
`endif
        .ld_data    (ld_data)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: plain memory array, per-word corruption flag, queue of expected responses.
    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    logic [31:0] mmem [DEPTH];
    bit          mbad [DEPTH];
    exp_t        q[$];
    bit          after_rst = 0;
    bit          live      = 0;

    always @(posedge clk) begin
        exp_t e;
        bit   acc;
        bit   pp;
        int   idx;
        if (reset) begin
            q.delete();
            after_rst = 1;
            live      = 1;
        end else begin
            after_rst = 0;
            acc    = req_valid && (q.size() < 2) && !flush;
            pp     = (q.size() > 0) && resp_ready;
            idx    = int'((req_addr / 4) % DEPTH);
            e.addr = req_addr;
            e.err  = (req_addr % 4 != 0) || (req_addr >= DEPTH * 4) || mbad[idx];
            e.inst = e.err ? NOP : mmem[idx];
            if (flush) q.delete();
            else begin
                if (pp) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
            if (ld_we) begin
                mmem[ld_addr] = ld_data;
                mbad[ld_addr] = inj;
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("req_ready", 32'(req_ready), 32'(q.size() < 2 && !flush && !reset));
            chk("resp_valid", 32'(resp_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                chk("resp_inst", resp_inst, q[0].inst);
                chk("resp_addr", resp_addr, q[0].addr);
                chk("resp_err", 32'(resp_err), 32'(q[0].err));
            end
            if (after_rst) begin
                chk("rst_inst", resp_inst, 32'h0);
                chk("rst_addr", resp_addr, 32'h0);
                chk("rst_err", 32'(resp_err), 32'h0);
            end
        end
    end

    // Drive one cycle of inputs, wait for the consuming edge, return 1 time unit after it.
    task automatic cyc(input logic v, input logic [31:0] a, input logic rr,
                       input logic fl = 1'b0, input logic rs = 1'b0, input logic we = 1'b0,
                       input logic [AW-1:0] la = '0, input logic [31:0] ld = '0,
                       input logic in = 1'b0);
        req_valid  = v;
        req_addr   = a;
        resp_ready = rr;
        flush      = fl;
        reset      = rs;
        ld_we      = we;
        ld_addr    = la;
        ld_data    = ld;
        inj        = in;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic rr);
        cyc(1'b1, a, rr);
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b1);
    endtask

    task automatic load(input logic [AW-1:0] i, input logic [31:0] d, input logic in = 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, i, d, in);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
        flush = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0; inj = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("lit_rst_valid", 32'(resp_valid), 32'h0);
        chk("lit_rst_inst", resp_inst, 32'h0);
        chk("lit_ready_in_reset", 32'(req_ready), 32'h0);

        load(0, 32'h11); load(1, 32'h22); load(2, 32'h33); load(3, 32'h44);
        load(10'd1023, 32'hDEAD_BEEF);

        // Back-to-back, always-ready consumer
        req(0, 1);  chk("lit_b2b_0", resp_inst, 32'h11);
        req(4, 1);  chk("lit_b2b_1", resp_inst, 32'h22);
        req(8, 1);  chk("lit_b2b_2", resp_inst, 32'h33);
        req(12, 1); chk("lit_b2b_3", resp_inst, 32'h44);
        idle();
        chk("lit_b2b_drained", 32'(resp_valid), 32'h0);

        // Stalled consumer fills the FIFO
        req(0, 0); req(4, 0);
        chk("lit_full_ready", 32'(req_ready), 32'h0);
        req(8, 0); chk("lit_hold_inst", resp_inst, 32'h11);
        req(8, 1); chk("lit_pop1_inst", resp_inst, 32'h22);
        req(8, 1); chk("lit_pop2_inst", resp_inst, 32'h33);
        idle();

        // Error classes and top-of-range boundary
        req(32'h6, 1);
        chk("lit_misal_err", 32'(resp_err), 32'h1);
        chk("lit_misal_inst", resp_inst, NOP);
        req(32'h1000, 1);
        chk("lit_oor_err", 32'(resp_err), 32'h1);
        chk("lit_oor_inst", resp_inst, NOP);
        req(32'hFFC, 1);
        chk("lit_last_err", 32'(resp_err), 32'h0);
        chk("lit_last_inst", resp_inst, 32'hDEAD_BEEF);
        idle();

        // Flush with a request pending
        req(0, 0); req(4, 0);
        cyc(1'b1, 32'h8, 1'b0, 1'b1);
        chk("lit_flush_valid", 32'(resp_valid), 32'h0);
        req(4, 1); chk("lit_after_flush", resp_inst, 32'h22);
        idle();

        // Same-edge load and fetch of the same word
        cyc(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 1'b1, 10'd1, 32'hAB);
        chk("lit_rbw_old", resp_inst, 32'h22);
        req(4, 1); chk("lit_rbw_new", resp_inst, 32'hAB);
        idle();

        // Reset with a full FIFO; the concurrent load must be dropped
        req(0, 0); req(8, 0);
        cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd2, 32'h99);
        chk("lit_midrst_valid", 32'(resp_valid), 32'h0);
        chk("lit_midrst_inst", resp_inst, 32'h0);
        req(0, 1); chk("lit_mem_kept", resp_inst, 32'h11);
        req(8, 1); chk("lit_ld_suppressed", resp_inst, 32'h33);
        idle();

`ifdef INST_MEM_PARITY_EN
        load(5, 32'h55, 1'b1);
        req(20, 1);
        chk("lit_par_err", 32'(resp_err), 32'h1);
        chk("lit_par_inst", resp_inst, NOP);
        load(5, 32'h55, 1'b0);
        req(20, 1);
        chk("lit_par_ok_err", 32'(resp_err), 32'h0);
        chk("lit_par_ok_inst", resp_inst, 32'h55);
        idle();
`endif

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Responder side of the instruction-fetch interface. The PC/fetch stage issues word addresses; this block returns instruction words.
- Owns the instruction memory array. A program-load write port preloads it.
- Valid/ready request and response channels, with a 2-entry response FIFO to absorb decode-stage stalls.
- A flush input drops responses that are queued but not yet taken when the PC jumps.

Parameters:
- DEPTH, 1024, instruction memory depth in 32-bit words (power of 2).
- AW, 10, word-index width, equal to log2(DEPTH). The index is req_addr[AW+1:2].
- NOP_INST, 32'h00000013, instruction word returned on an error response.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  block can accept a request this cycle.
- req_addr  in  32  byte address of the instruction.
- resp_valid  out  1  response at FIFO head is valid.
- resp_ready  in  1  consumer takes the head response this cycle.
- resp_inst  out  32  instruction word at FIFO head.
- resp_addr  out  32  request address matching resp_inst.
- resp_err  out  1  head response is misaligned, out of range (or parity error, if enabled).
- flush  in  1  discard all queued responses (jump taken).
- ld_we  in  1  program-load write enable.
- ld_addr  in  AW  word index for the load write.
- ld_data  in  32  word to write.

Behaviour:
- Reset, synchronous, when reset=1 at a posedge:
  - FIFO count=0, read/write pointers=0.
  - resp_valid=0, resp_inst=0, resp_addr=0, resp_err=0.
  - Memory contents are not cleared.
  - Reset overrides flush, requests and loads in the same cycle; the ld write is suppressed.
- req_ready = (count<2) && !flush && !reset. It is purely combinational from state and has no path from resp_ready.
- Accept: req_valid && req_ready at a posedge.
  - The memory is read at the index and {inst, addr, err} is pushed into the FIFO at that same edge.
  - resp_valid is therefore high in the cycle after acceptance (latency 1).
- Pop: resp_valid && resp_ready at a posedge advances the read pointer.
- Simultaneous push and pop: count is unchanged. Back-to-back accepts every cycle give full throughput with a consumer that is always ready.
- FIFO full (count=2): req_ready=0. A pop that cycle does not re-open the FIFO until the next cycle.
- Error classes:
  - addr[1:0]!=0: resp_err=1, resp_inst=NOP_INST.
  - addr >= DEPTH*4: resp_err=1, resp_inst=NOP_INST.
  - Otherwise: resp_err=0, resp_inst=mem[index].
- Flush: when flush=1 at a posedge, count, rptr and wptr go to 0 and resp_valid=0 next cycle. No request is accepted in a flush cycle.
- Load: ld_we=1 writes mem[ld_addr]=ld_data at the posedge.
  - Same-cycle accept of the same index returns the old word (read-before-write).
  - Loads are legal at any time except during reset.
- resp_* outputs are registered head-of-FIFO values. They hold stable while resp_valid && !resp_ready.

Optional Feature:
- Macro: INST_MEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed from ld_data at load.
  - On read, a parity mismatch sets resp_err=1 and replaces resp_inst with NOP_INST.
  - Adds input inject_par_err (1 bit). When ld_we=1 and inject_par_err=1, the stored parity bit is inverted; this is for test only.
- Undefined: no parity storage, no inject_par_err port. Errors come only from misalignment or range.

Decomposition:
- Shared package/defines file holds:
  - NOP_INST constant.
  - Default DEPTH.
  - Response-entry field widths (inst 32, addr 32, err 1).
- One natural sub-module: resp_fifo2, a generic 2-entry valid/ready FIFO with synchronous clear and parameter WIDTH=65.
- The memory array and error classification stay in inst_mem_responder.

Test Plan:
- Load mem[0..3]=32'h11,22,33,44. Request addrs 0,4,8,12 back-to-back with resp_ready=1 → resp_valid from cycle 2 onward, resp_inst 11,22,33,44 in order, req_ready never drops.
- resp_ready=0, issue 3 requests (0,4,8) → first two accepted; req_ready=0 after count=2; resp_inst=11 holds stable. Raise resp_ready → 11, 22 popped, then addr 8 accepted.
- Request addr 32'h6 → resp_err=1, resp_inst=32'h00000013. Request addr 32'h1000 (DEPTH=1024) → resp_err=1, resp_inst=32'h00000013.
- Queue 2 responses, assert flush for one cycle with req_valid=1 → resp_valid=0 next cycle, request not accepted. The next request, addr 4, returns 22.
- Same cycle: ld_we=1 for index 1 with 32'hAB, and accept of addr 4 → response 22. A following request to addr 4 → 32'hAB.
- Assert reset mid-stream with count=2 → resp_valid=0, resp_inst=0 next cycle. A subsequent request to addr 0 → 11 (memory retained). With INST_MEM_PARITY_EN, load index 0 with inject_par_err=1 → resp_err=1.
